// File: rtl/spiker_result_packer_if.sv
// Handshake bundle between the spiker core, the result packer and the register file.
// Signal suffixes are relative to the packer: the packer connects through the slave modport.
interface spiker_result_packer_if #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784
);
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic                result_valid_i;
  logic                result_ready_o;
  logic [N_SPIKES-1:0] result_i;
  logic                word_valid_o;
  logic                word_ready_i;
  logic [WIDTH-1:0]    word_data_o;
  logic [IDX_W-1:0]    word_idx_o;
  logic                word_last_o;

  modport slave (
    input  result_valid_i, result_i, word_ready_i,
    output result_ready_o, word_valid_o, word_data_o, word_idx_o, word_last_o
  );

  modport master (
    output result_valid_i, result_i, word_ready_i,
    input  result_ready_o, word_valid_o, word_data_o, word_idx_o, word_last_o
  );
endinterface

// File: rtl/spiker_result_packer.sv
// Captures a flat spike result vector and streams it as WIDTH-bit words to the register
// file, counting set spikes on the way and pulsing done_o once the last word is accepted.
module spiker_result_packer #(
  parameter  int WIDTH    = 32,
  parameter  int N_SPIKES = 784,
  localparam int N_WORDS  = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int CNT_W    = $clog2(N_SPIKES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         test_mode_i,
  input  logic                         clear_i,
  spiker_result_packer_if.slave        bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             spike_count_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  // Index of the word before the last one; loading last_q from it keeps word_last_o registered.
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'((N_WORDS > 1) ? N_WORDS - 2 : 0);

  state_e                     state_q;
  logic [N_WORDS*WIDTH-1:0]   shadow_q;
  logic [N_WORDS*WIDTH-1:0]   shadow_d;
  logic [IDX_W-1:0]           idx_q;
  logic [CNT_W-1:0]           run_q;
  logic [CNT_W-1:0]           spike_q;
  logic [CNT_W-1:0]           word_pop;
  logic                       ready_q;
  logic                       valid_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       last_q;
  logic                       unused_test_mode;

  assign unused_test_mode = test_mode_i;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(w[i]);
    return n;
  endfunction

  // NOTE: every always_comb output gets a full default first so no latch can be inferred.
  always_comb begin
    shadow_d                 = '0;
    shadow_d[N_SPIKES-1:0]   = bus.result_i;
  end

  // The shadow register shifts down on each accepted word, so the current word is always the low slice.
  assign word_pop = popcount(shadow_q[WIDTH-1:0]);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      run_q    <= '0;
      spike_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        state_q <= IDLE;
        idx_q   <= '0;
        run_q   <= '0;
        spike_q <= '0;
        ready_q <= 1'b1;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.result_valid_i && ready_q) begin
              state_q  <= SEND;
              shadow_q <= shadow_d;
              idx_q    <= '0;
              run_q    <= '0;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
              last_q   <= (N_WORDS == 1);
            end
          end
          SEND: begin
            if (valid_q && bus.word_ready_i) begin
              run_q <= run_q + word_pop;
              if (last_q) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                spike_q <= run_q + word_pop;
              end else begin
                shadow_q <= shadow_q >> WIDTH;
                idx_q    <= idx_q + 1'b1;
                last_q   <= (idx_q == PRE_LAST);
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.result_ready_o = ready_q;
  assign bus.word_valid_o   = valid_q;
  assign bus.word_data_o    = shadow_q[WIDTH-1:0];
  assign bus.word_idx_o     = idx_q;
  assign bus.word_last_o    = last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign spike_count_o      = spike_q;

endmodule

// File: tb/tb_spiker_result_packer.sv
// Scoreboard bench for spiker_result_packer: default 32/784 instance plus an 8/16 instance.
module tb_spiker_result_packer;

  localparam int W  = 32;
  localparam int NS = 784;
  localparam int NW = 25;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic test_mode;
  logic clear;
  logic busy, done;
  logic [9:0] spike_count;
  logic s_busy, s_done;
  logic [4:0] s_spike_count;

  int checks = 0;
  int errors = 0;

  word_t exp_q[$];
  int    cnt_q[$];
  word_t s_exp_q[$];
  int    s_cnt_q[$];

  always #5 clk = ~clk;

  spiker_result_packer_if #(.WIDTH(W), .N_SPIKES(NS)) bus ();
  spiker_result_packer_if #(.WIDTH(8), .N_SPIKES(16)) s_bus ();

  spiker_result_packer #(.WIDTH(W), .N_SPIKES(NS)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_mode_i   (test_mode),
    .clear_i       (clear),
    .bus           (bus),
    .busy_o        (busy),
    .done_o        (done),
    .spike_count_o (spike_count)
  );

  spiker_result_packer #(.WIDTH(8), .N_SPIKES(16)) dut_s (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_mode_i   (1'b0),
    .clear_i       (1'b0),
    .bus           (s_bus),
    .busy_o        (s_busy),
    .done_o        (s_done),
    .spike_count_o (s_spike_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for the wide instance: pops on every handshake, checks stability across stalls.
  logic  stall_prev = 1'b0;
  word_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.word_valid_o) begin
        check("stall_data", bus.word_data_o, held.data);
        check("stall_idx",  bus.word_idx_o,  held.idx);
        check("stall_last", bus.word_last_o, held.last);
      end
      if (bus.word_valid_o && bus.word_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", exp_q.size(), 1);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", bus.word_data_o, e.data);
          check("word_idx",  bus.word_idx_o,  e.idx);
          check("word_last", bus.word_last_o, e.last);
        end
      end
      stall_prev = bus.word_valid_o && !bus.word_ready_i;
      held.data  = bus.word_data_o;
      held.idx   = bus.word_idx_o;
      held.last  = bus.word_last_o;
      if (done) begin
        if (cnt_q.size() == 0) check("unexpected_done", cnt_q.size(), 1);
        else                   check("done_count", spike_count, cnt_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_bus.word_valid_o && s_bus.word_ready_i) begin
        if (s_exp_q.size() == 0) begin
          check("s_unexpected_word", s_exp_q.size(), 1);
        end else begin
          word_t e;
          e = s_exp_q.pop_front();
          check("s_word_data", s_bus.word_data_o, e.data);
          check("s_word_idx",  s_bus.word_idx_o,  e.idx);
          check("s_word_last", s_bus.word_last_o, e.last);
        end
      end
      if (s_done) begin
        if (s_cnt_q.size() == 0) check("s_unexpected_done", s_cnt_q.size(), 1);
        else                     check("s_done_count", s_spike_count, s_cnt_q.pop_front());
      end
    end
  end

  // Waits for ready, presents v for one capture cycle and pushes the first n_exp expected words.
  // Called and returns at posedge+1; on return the first word is on the bus.
  task automatic send_result(input logic [NS-1:0] v, input int n_exp);
    logic [NW*W-1:0] pad;
    word_t e;
    int n = 0;
    while (!bus.result_ready_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("ready_timeout", bus.result_ready_o, 1);
    pad = '0;
    pad[NS-1:0] = v;
    for (int w = 0; w < n_exp; w++) begin
      e.data = pad[w*W +: W];
      e.idx  = 5'(w);
      e.last = (w == NW - 1);
      exp_q.push_back(e);
    end
    if (n_exp == NW) cnt_q.push_back($countones(v));
    bus.result_i       = v;
    bus.result_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.result_valid_i = 1'b0;
  endtask

  // Runs until done_o; cycles counts from the first cycle after capture.
  task automatic run_until_done(input bit random_stall, output int cycles);
    cycles = 1;
    for (int i = 0; i < 2000; i++) begin
      if (random_stall) bus.word_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (done) begin
        bus.word_ready_i = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("done_timeout", done, 1);
    bus.word_ready_i = 1'b1;
  endtask

  initial begin
    logic [NS-1:0] v_ones, v_mod3, v_a, v_b, v_c;
    int cyc;
    word_t e;

    for (int k = 0; k < NS; k++) begin
      v_ones[k] = 1'b1;
      v_mod3[k] = (k % 3 == 0);
      v_a[k]    = (k % 2 == 0);
      v_c[k]    = (k % 7 == 1);
    end
    v_b = ~v_a;

    rst_n                = 1'b0;
    test_mode            = 1'b0;
    clear                = 1'b0;
    bus.result_valid_i   = 1'b0;
    bus.result_i         = '0;
    bus.word_ready_i     = 1'b1;
    s_bus.result_valid_i = 1'b0;
    s_bus.result_i       = '0;
    s_bus.word_ready_i   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.result_ready_o, 1);
    check("rst_valid", bus.word_valid_o, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_count", spike_count, 0);
    @(posedge clk); #1;

    // 1: all ones, ready tied high, done_o in cycle NW+1.
    send_result(v_ones, NW);
    run_until_done(1'b0, cyc);
    check("t1_done_cycle", cyc, 26);
    check("t1_count", spike_count, 784);
    check("t1_idle_ready", bus.result_ready_o, 1);

    // 2: every third spike, random stalls, DFT pin toggled.
    test_mode = 1'b1;
    send_result(v_mod3, NW);
    run_until_done(1'b1, cyc);
    check("t2_count", spike_count, 262);
    test_mode = 1'b0;

    // 3: a different vector offered while busy must be ignored.
    send_result(v_a, NW);
    bus.result_i       = v_b;
    bus.result_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_busy", bus.result_ready_o, 0);
      @(posedge clk); #1;
    end
    bus.result_valid_i = 1'b0;
    run_until_done(1'b0, cyc);
    check("t3_count_a", spike_count, 392);
    send_result(v_b, NW);
    run_until_done(1'b0, cyc);
    check("t3_count_b", spike_count, 392);

    // 4: clear together with the handshake of word 10.
    send_result(v_mod3, 11);
    for (int i = 0; i < 50 && bus.word_idx_o != 5'd10; i++) begin
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("t4_ready",  bus.result_ready_o, 1);
    check("t4_valid",  bus.word_valid_o, 0);
    check("t4_busy",   busy, 0);
    check("t4_count",  spike_count, 0);
    check("t4_no_done", done, 0);
    @(posedge clk); #1;
    check("t4_queue_drained", exp_q.size(), 0);
    send_result(v_c, NW);
    run_until_done(1'b0, cyc);
    check("t4_restart_count", spike_count, 112);

    // 5: asynchronous reset in the middle of a transfer.
    send_result(v_ones, NW);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_ready", bus.result_ready_o, 1);
    check("t5_valid", bus.word_valid_o, 0);
    check("t5_data",  bus.word_data_o, 0);
    check("t5_idx",   bus.word_idx_o, 0);
    check("t5_last",  bus.word_last_o, 0);
    check("t5_busy",  busy, 0);
    check("t5_done",  done, 0);
    check("t5_count", spike_count, 0);
    exp_q.delete();
    cnt_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_result(v_mod3, NW);
    run_until_done(1'b0, cyc);
    check("t5_after_count", spike_count, 262);

    // 6: narrow instance, 16 spikes in two 8-bit words.
    e.data = 32'h3C; e.idx = 5'd0; e.last = 1'b0; s_exp_q.push_back(e);
    e.data = 32'hA5; e.idx = 5'd1; e.last = 1'b1; s_exp_q.push_back(e);
    s_cnt_q.push_back(8);
    s_bus.result_i       = 16'hA53C;
    s_bus.result_valid_i = 1'b1;
    @(posedge clk); #1;
    s_bus.result_valid_i = 1'b0;
    for (int i = 0; i < 20 && !s_done; i++) begin
      @(posedge clk); #1;
    end
    check("t6_done_seen", s_done, 1);
    @(posedge clk); #1;
    check("t6_count", s_spike_count, 8);

    check("end_words_left", exp_q.size(), 0);
    check("end_counts_left", cnt_q.size(), 0);
    check("end_s_words_left", s_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
